core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the CPU datapath (ProgramCounter, Decoder, GPRegister, ALU).
//  Sequences each instruction as FETCH -> DECODE -> EXEC -> WB against a req/ack instruction memory.
//  Drives the instruction-register load, register-file write and PC-increment enables.
//  Fetch timeout detection; run/halt control at instruction boundaries.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max FETCH cycles without ack before error (>=2)
//  CNT_W           32  width of performance counters (SEQ_PERF_CNT_EN only)
// PORTS
//  i_clock      in   1      clock, rising edge
//  i_resetn     in   1      asynchronous active-low reset
//  i_run        in   1      level; high = keep executing, low = stop at next boundary
//  o_imemReq    out  1      instruction fetch request
//  i_imemAck    in   1      fetch data valid on i_imemData this cycle
//  o_irLoad     out  1      latch instruction (= FETCH & i_imemAck, combinational)
//  o_rfWe       out  1      register-file write enable, 1-cycle pulse in WB
//  o_pcInc      out  1      PC advance enable, 1-cycle pulse in WB
//  o_busy       out  1      high in FETCH/DECODE/EXEC/WB
//  o_halted     out  1      high in IDLE/ERR
//  o_fetchErr   out  1      sticky fetch-timeout flag
//  i_errClr     in   1      clears ERR state and o_fetchErr
//  o_state      out  3      current state encoding
//  o_retireCnt  out  CNT_W  retired instructions (SEQ_PERF_CNT_EN only)
//  o_stallCnt   out  CNT_W  FETCH cycles without ack (SEQ_PERF_CNT_EN only)
// BEHAVIOUR
//  - States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, ERR=5; 6,7 unreachable -> IDLE.
//  - Reset (async, any state): IDLE, wait counter 0, o_fetchErr=0, perf counters 0.
//    Outputs: o_halted=1, o_state=0, all others 0. Instruction in flight is aborted; no o_rfWe/o_pcInc.
//  - IDLE: i_run=1 -> FETCH next cycle; otherwise stay.
//  - FETCH: o_imemReq=1, held stable until ack.
//    - i_imemAck=1 -> DECODE; o_irLoad=1 same cycle.
//    - No ack: wait counter increments. Timeout when the counter reaches TIMEOUT_CYCLES-1 without ack
//      (i.e. TIMEOUT_CYCLES FETCH cycles) -> ERR, o_fetchErr set.
//    - Ack in the timeout cycle wins: go to DECODE, no error.
//    - Wait counter clears on FETCH entry.
//  - DECODE: 1 cycle -> EXEC.  EXEC: 1 cycle -> WB.
//  - WB: o_rfWe=1, o_pcInc=1 for exactly this cycle; i_run=1 -> FETCH, else -> IDLE.
//  - i_run low mid-instruction: current instruction completes through WB, then IDLE; no new request.
//  - ERR: o_halted=1, i_run ignored.
//    - i_errClr=1 -> IDLE next cycle, o_fetchErr cleared on that same edge.
//    - i_errClr outside ERR: no effect.
//  - i_imemAck outside FETCH: ignored.
//  - Latency: ack in first FETCH cycle -> 4 cycles/instruction; each ack delay adds 1 cycle.
//  - o_state, o_busy, o_halted, o_rfWe, o_pcInc, o_imemReq: decoded from the state register only (Moore).
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined:
//    - o_retireCnt +1 on each WB cycle.
//    - o_stallCnt +1 on each FETCH cycle with i_imemAck=0.
//    - Both saturate at all-ones; reset to 0.
//  SEQ_PERF_CNT_EN undefined: both ports and counters absent; FSM behaviour identical.
// TESTING
//  1. Reset, i_run=1, ack tied 1:
//     o_state 1,2,3,4,1,...; o_pcInc/o_rfWe every 4th cycle; 3 retirements after 12 cycles.
//  2. Ack delayed 3 cycles:
//     FETCH lasts 4 cycles, instruction 7 cycles; o_irLoad 1 pulse; o_stallCnt=3, o_retireCnt=1.
//  3. TIMEOUT_CYCLES=16, ack never:
//     ERR after 16 FETCH cycles; o_fetchErr=1, o_halted=1, o_imemReq=0.
//     i_errClr pulse -> IDLE, o_fetchErr=0.
//  4. Ack first asserted on 16th FETCH cycle -> DECODE, o_fetchErr stays 0.
//  5. i_run dropped during EXEC:
//     WB pulses o_rfWe/o_pcInc once, then IDLE, o_halted=1, no further o_imemReq.
//  6. i_resetn low mid-EXEC:
//     immediate IDLE, o_rfWe=0, o_busy=0, counters 0; restart with i_run=1 -> FETCH.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Handshake bundle between core_sequencer (master) and the datapath/instruction memory (slave).
// Performance counter signals exist only when SEQ_PERF_CNT_EN is defined.
interface core_sequencer_if
`ifdef SEQ_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
();
    logic       i_run;
    logic       o_imemReq;
    logic       i_imemAck;
    logic       o_irLoad;
    logic       o_rfWe;
    logic       o_pcInc;
    logic       o_busy;
    logic       o_halted;
    logic       o_fetchErr;
    logic       i_errClr;
    logic [2:0] o_state;
`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] o_retireCnt;
    logic [CNT_W-1:0] o_stallCnt;
`endif

    modport master (
`ifdef SEQ_PERF_CNT_EN
        output o_retireCnt, o_stallCnt,
`endif
        input  i_run, i_imemAck, i_errClr,
        output o_imemReq, o_irLoad, o_rfWe, o_pcInc, o_busy, o_halted, o_fetchErr, o_state
    );

    modport slave (
`ifdef SEQ_PERF_CNT_EN
        input  o_retireCnt, o_stallCnt,
`endif
        output i_run, i_imemAck, i_errClr,
        input  o_imemReq, o_irLoad, o_rfWe, o_pcInc, o_busy, o_halted, o_fetchErr, o_state
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control FSM with fetch timeout and run/halt at boundaries.
// Optional saturating retire/stall counters are built when SEQ_PERF_CNT_EN is defined.
module core_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
`ifdef SEQ_PERF_CNT_EN
   ,parameter int CNT_W = 32
`endif
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    core_sequencer_if.master  bus
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                timeout;
    logic                fetch_err;
    logic                imem_req;
    logic                rf_we;
    logic                pc_inc;
    logic                busy;
    logic                halted;

    // An ack in the final allowed cycle takes priority over the timeout.
    assign timeout = (state == FETCH) && !bus.i_imemAck &&
                     (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = bus.i_run ? FETCH : IDLE;
            FETCH: begin
                if (bus.i_imemAck) state_n = DECODE;
                else if (timeout)  state_n = ERR;
                else               state_n = FETCH;
            end
            DECODE:  state_n = EXEC;
            EXEC:    state_n = WB;
            WB:      state_n = bus.i_run ? FETCH : IDLE;
            ERR:     state_n = bus.i_errClr ? IDLE : ERR;
            default: state_n = IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
            imem_req  <= 1'b0;
            rf_we     <= 1'b0;
            pc_inc    <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b1;
        end else begin
            state <= state_n;
            if (state != FETCH)       wait_cnt <= '0;
            else if (!bus.i_imemAck)  wait_cnt <= wait_cnt + 1'b1;
            if (timeout)                          fetch_err <= 1'b1;
            else if (state == ERR && bus.i_errClr) fetch_err <= 1'b0;
            imem_req <= (state_n == FETCH);
            rf_we    <= (state_n == WB);
            pc_inc   <= (state_n == WB);
            busy     <= (state_n == FETCH) || (state_n == DECODE) ||
                        (state_n == EXEC)  || (state_n == WB);
            halted   <= (state_n == IDLE) || (state_n == ERR);
        end
    end

    assign bus.o_state    = state;
    assign bus.o_imemReq  = imem_req;
    assign bus.o_irLoad   = (state == FETCH) && bus.i_imemAck;
    assign bus.o_rfWe     = rf_we;
    assign bus.o_pcInc    = pc_inc;
    assign bus.o_busy     = busy;
    assign bus.o_halted   = halted;
    assign bus.o_fetchErr = fetch_err;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (state == WB && retire_cnt != '1)
                retire_cnt <= retire_cnt + 1'b1;
            if (state == FETCH && !bus.i_imemAck && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.o_retireCnt = retire_cnt;
    assign bus.o_stallCnt  = stall_cnt;
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: sequencing, fetch stalls, timeout/error recovery, run drop, reset abort.
// Counter checks are compiled in when SEQ_PERF_CNT_EN is defined.
module tb_core_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

`ifdef SEQ_PERF_CNT_EN
    core_sequencer_if #(.CNT_W(32)) bus ();
    core_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
        .i_clock (clk),
        .i_resetn(rst_n),
        .bus     (bus)
    );
`else
    core_sequencer_if bus ();
    core_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .i_clock (clk),
        .i_resetn(rst_n),
        .bus     (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.i_run = 1'b0;
        bus.i_imemAck = 1'b0;
        bus.i_errClr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.i_run = 1'b1;
        bus.i_imemAck = 1'b1;
        bus.i_errClr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", bus.o_state); end
        checks++; if (bus.o_halted !== 1'b1) begin failures++; $display("FAIL rst_halted got=%0b exp=1", bus.o_halted); end
        checks++; if ({bus.o_imemReq, bus.o_irLoad, bus.o_rfWe, bus.o_pcInc, bus.o_busy, bus.o_fetchErr} !== 6'b0) begin
            failures++; $display("FAIL rst_outputs got=%b exp=000000",
                {bus.o_imemReq, bus.o_irLoad, bus.o_rfWe, bus.o_pcInc, bus.o_busy, bus.o_fetchErr});
        end
`ifdef SEQ_PERF_CNT_EN
        checks++; if (bus.o_retireCnt !== 32'd0 || bus.o_stallCnt !== 32'd0) begin
            failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", bus.o_retireCnt, bus.o_stallCnt);
        end
`endif
    endtask

    task automatic test_ack_tied;
        int pulses;
        pulses = 0;
        do_reset();
        bus.i_run = 1'b1;
        bus.i_imemAck = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++; if (bus.o_state !== 3'((i % 4) + 1)) begin
                failures++; $display("FAIL t1_state cyc=%0d got=%0d exp=%0d", i, bus.o_state, (i % 4) + 1);
            end
            checks++; if (bus.o_rfWe !== (i % 4 == 3)) begin
                failures++; $display("FAIL t1_rfwe cyc=%0d got=%0b exp=%0b", i, bus.o_rfWe, (i % 4 == 3));
            end
            checks++; if (bus.o_irLoad !== (i % 4 == 0)) begin
                failures++; $display("FAIL t1_irload cyc=%0d got=%0b exp=%0b", i, bus.o_irLoad, (i % 4 == 0));
            end
            if (bus.o_pcInc === 1'b1) pulses++;
        end
        checks++; if (pulses != 3) begin failures++; $display("FAIL t1_pcinc_pulses got=%0d exp=3", pulses); end
        bus.i_run = 1'b0;
        tick();
        checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL t1_stop_state got=%0d exp=0", bus.o_state); end
`ifdef SEQ_PERF_CNT_EN
        checks++; if (bus.o_retireCnt !== 32'd3) begin failures++; $display("FAIL t1_retire got=%0d exp=3", bus.o_retireCnt); end
        checks++; if (bus.o_stallCnt !== 32'd0) begin failures++; $display("FAIL t1_stall got=%0d exp=0", bus.o_stallCnt); end
`endif
    endtask

    task automatic test_ack_delay;
        int irl;
        int fetch_cycles;
        int busy_cycles;
        irl = 0; fetch_cycles = 0; busy_cycles = 0;
        do_reset();
        bus.i_run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.i_imemAck = (i == 3);
            if (i >= 1) bus.i_run = 1'b0;
            #1;
            if (bus.o_irLoad === 1'b1) irl++;
            if (bus.o_state === 3'd1) fetch_cycles++;
            if (bus.o_busy === 1'b1) busy_cycles++;
            if (i == 3) begin
                checks++; if (bus.o_imemReq !== 1'b1) begin failures++; $display("FAIL t2_req_held got=%0b exp=1", bus.o_imemReq); end
            end
        end
        checks++; if (bus.o_state !== 3'd4) begin failures++; $display("FAIL t2_wb_state got=%0d exp=4", bus.o_state); end
        checks++; if (irl != 1) begin failures++; $display("FAIL t2_irload_pulses got=%0d exp=1", irl); end
        checks++; if (fetch_cycles != 4) begin failures++; $display("FAIL t2_fetch_cycles got=%0d exp=4", fetch_cycles); end
        checks++; if (busy_cycles != 7) begin failures++; $display("FAIL t2_instr_cycles got=%0d exp=7", busy_cycles); end
        tick();
        checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL t2_idle got=%0d exp=0", bus.o_state); end
`ifdef SEQ_PERF_CNT_EN
        checks++; if (bus.o_stallCnt !== 32'd3) begin failures++; $display("FAIL t2_stall got=%0d exp=3", bus.o_stallCnt); end
        checks++; if (bus.o_retireCnt !== 32'd1) begin failures++; $display("FAIL t2_retire got=%0d exp=1", bus.o_retireCnt); end
`endif
    endtask

    task automatic test_timeout;
        do_reset();
        bus.i_run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (bus.o_state !== 3'd1 || bus.o_fetchErr !== 1'b0) begin
                failures++; $display("FAIL t3_fetch cyc=%0d state=%0d err=%0b exp=1/0", i, bus.o_state, bus.o_fetchErr);
            end
        end
        tick();
        checks++; if (bus.o_state !== 3'd5) begin failures++; $display("FAIL t3_err_state got=%0d exp=5", bus.o_state); end
        checks++; if ({bus.o_fetchErr, bus.o_halted, bus.o_imemReq, bus.o_busy} !== 4'b1100) begin
            failures++; $display("FAIL t3_err_flags got=%b exp=1100", {bus.o_fetchErr, bus.o_halted, bus.o_imemReq, bus.o_busy});
        end
`ifdef SEQ_PERF_CNT_EN
        checks++; if (bus.o_stallCnt !== 32'd16) begin failures++; $display("FAIL t3_stall got=%0d exp=16", bus.o_stallCnt); end
`endif
        bus.i_imemAck = 1'b1;
        tick();
        checks++; if (bus.o_state !== 3'd5 || bus.o_fetchErr !== 1'b1) begin
            failures++; $display("FAIL t3_err_hold state=%0d err=%0b exp=5/1", bus.o_state, bus.o_fetchErr);
        end
        bus.i_imemAck = 1'b0;
        bus.i_run = 1'b0;
        bus.i_errClr = 1'b1;
        tick();
        bus.i_errClr = 1'b0;
        checks++; if (bus.o_state !== 3'd0 || bus.o_fetchErr !== 1'b0) begin
            failures++; $display("FAIL t3_clear state=%0d err=%0b exp=0/0", bus.o_state, bus.o_fetchErr);
        end
    endtask

    task automatic test_late_ack;
        do_reset();
        bus.i_run = 1'b1;
        bus.i_errClr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.i_imemAck = (i == 15);
            #1;
            checks++; if (bus.o_state !== 3'd1) begin failures++; $display("FAIL t4_fetch cyc=%0d got=%0d exp=1", i, bus.o_state); end
        end
        checks++; if (bus.o_irLoad !== 1'b1) begin failures++; $display("FAIL t4_irload got=%0b exp=1", bus.o_irLoad); end
        tick();
        bus.i_imemAck = 1'b0;
        bus.i_errClr = 1'b0;
        bus.i_run = 1'b0;
        #1;
        checks++; if (bus.o_state !== 3'd2 || bus.o_fetchErr !== 1'b0) begin
            failures++; $display("FAIL t4_decode state=%0d err=%0b exp=2/0", bus.o_state, bus.o_fetchErr);
        end
        repeat (3) tick();
        checks++; if (bus.o_state !== 3'd0 || bus.o_fetchErr !== 1'b0) begin
            failures++; $display("FAIL t4_done state=%0d err=%0b exp=0/0", bus.o_state, bus.o_fetchErr);
        end
    endtask

    task automatic test_run_drop;
        do_reset();
        bus.i_run = 1'b1;
        bus.i_imemAck = 1'b1;
        repeat (3) tick();
        checks++; if (bus.o_state !== 3'd3) begin failures++; $display("FAIL t5_exec got=%0d exp=3", bus.o_state); end
        bus.i_run = 1'b0;
        tick();
        checks++; if ({bus.o_rfWe, bus.o_pcInc} !== 2'b11) begin
            failures++; $display("FAIL t5_wb_pulse got=%b exp=11", {bus.o_rfWe, bus.o_pcInc});
        end
        tick();
        checks++; if ({bus.o_halted, bus.o_rfWe, bus.o_pcInc} !== 3'b100 || bus.o_state !== 3'd0) begin
            failures++; $display("FAIL t5_idle got=%b state=%0d exp=100/0", {bus.o_halted, bus.o_rfWe, bus.o_pcInc}, bus.o_state);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.o_imemReq !== 1'b0 || bus.o_state !== 3'd0) begin
                failures++; $display("FAIL t5_no_req cyc=%0d req=%0b state=%0d exp=0/0", i, bus.o_imemReq, bus.o_state);
            end
        end
    endtask

    task automatic test_reset_mid_exec;
        do_reset();
        bus.i_run = 1'b1;
        bus.i_imemAck = 1'b1;
        repeat (7) tick();
        checks++; if (bus.o_state !== 3'd3) begin failures++; $display("FAIL t6_exec got=%0d exp=3", bus.o_state); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_state !== 3'd0 || bus.o_busy !== 1'b0 || bus.o_halted !== 1'b1) begin
            failures++; $display("FAIL t6_abort state=%0d busy=%0b halted=%0b exp=0/0/1", bus.o_state, bus.o_busy, bus.o_halted);
        end
`ifdef SEQ_PERF_CNT_EN
        checks++; if (bus.o_retireCnt !== 32'd0) begin failures++; $display("FAIL t6_retire got=%0d exp=0", bus.o_retireCnt); end
`endif
        tick();
        checks++; if (bus.o_rfWe !== 1'b0 || bus.o_pcInc !== 1'b0) begin
            failures++; $display("FAIL t6_no_wb got=%b exp=00", {bus.o_rfWe, bus.o_pcInc});
        end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.o_state !== 3'd1 || bus.o_imemReq !== 1'b1) begin
            failures++; $display("FAIL t6_restart state=%0d req=%0b exp=1/1", bus.o_state, bus.o_imemReq);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.i_run = 1'b0;
        bus.i_imemAck = 1'b0;
        bus.i_errClr = 1'b0;
        test_reset();
        test_ack_tied();
        test_ack_delay();
        test_timeout();
        test_late_ack();
        test_run_drop();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
